mux_dff_deser: RTL and testbench
================================

# mux_dff_deser

Serial-in/parallel-out receiver that reassembles words from the single-bit stream produced by the team's mux/DFF parallel-load shift chain. It shifts in one bit of `w` per enabled cycle, counts bits against `WIDTH`, and presents each completed word on `Q` with a valid/ready handshake. It sits at the receiving end of the serial link, feeding the downstream word consumer.

## Interface
- `WIDTH`, default 4: bits per word; legal range 2..32.
- `MSB_FIRST`, default 1: 1 places the first received bit in `Q[WIDTH-1]`; 0 places it in `Q[0]`.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `w`  in  1  serial data bit, sampled when `E`=1.
- `E`  in  1  bit enable; one bit of `w` is accepted per cycle with `E`=1.
- `L`  in  1  frame sync; discards any partial word and restarts bit count.
- `Q`  out  WIDTH  last completed word.
- `q_valid`  out  1  `Q` holds an unconsumed word.
- `q_ready`  in  1  consumer accepts `Q` when `q_valid`&&`q_ready`.
- `overrun`  out  1  sticky; a completed word was dropped.

## Operation
- Reset: shift register=0, bit count=0, state COLLECT, `Q`=0, `q_valid`=0, `overrun`=0.
- FSM states: COLLECT (accumulating, no word pending), PENDING (word on `Q` not yet consumed; accumulation continues).
- Shift on `E`=1: MSB_FIRST=1 → sr <= {sr[WIDTH-2:0], w}; MSB_FIRST=0 → sr <= {w, sr[WIDTH-1:1]}. `E`=0: sr and count hold.
- Bit count runs 0..WIDTH-1; accepting the bit at count WIDTH-1 completes the word, count wraps to 0.
- Word completion: the completed word (sr with the new bit included) loads into `Q`, `q_valid`<=1, state → PENDING.
- Completion while PENDING and handshake not occurring that cycle: new word dropped, `Q` unchanged, `overrun`<=1 (held until `reset`).
- Completion while PENDING with `q_valid`&&`q_ready` same cycle: new word loads into `Q`, `q_valid` stays 1, no overrun.
- Handshake without completion: `q_valid`<=0, state → COLLECT; `Q` retains its value.
- `L`=1: count<=0, sr<=0. If `E`=1 same cycle, `w` is shifted in as bit 1 of the new word (count<=1). `L` never affects `Q`, `q_valid`, or `overrun`; a word completing on the `L` cycle is discarded without overrun.
- `reset` overrides `L`, `E`, and handshake in the same cycle.

## Timing
- Latency: bit that completes a word sampled at edge t; `Q`/`q_valid` valid after edge t (visible in cycle t+1).
- Throughput: one bit per cycle; one word per WIDTH enabled cycles; consumer has WIDTH-1 cycles of slack before overrun at full rate.
- `q_valid` drops the edge after the accepting handshake; no combinational path from `q_ready` or `w` to any output.
- Reset mid-word or mid-PENDING: all state cleared on that edge; partial and pending words lost.

## Structure
- Package `mux_dff_pkg`: state enum `deser_state_t` {COLLECT, PENDING}; function `cnt_w(WIDTH)` returning $clog2(WIDTH) for the counter width.
- Sub-module `mux_dff_stage`: one register bit with priority clear (`L`) > shift (`E`) > hold, instantiated WIDTH times via generate; top level holds counter, FSM, output register, and overrun flag.

## Test plan
- Reset, then `E`=1 with `w`=1,1,0,0 (MSB_FIRST=1, WIDTH=4), `q_ready`=1 → `Q`=4'hC, `q_valid`=1 for exactly one cycle, `overrun`=0.
- Same stream with MSB_FIRST=0 → `Q`=4'h3.
- `E` toggling 1,0,1,0,… over bits 1,0,1,0 → `Q`=4'hA after 8 cycles; count holds on `E`=0.
- `q_ready`=0, send 4'h5 then 4'h9 → `Q` stays 4'h5, `overrun`=1 after 8th bit; assert `q_ready` → `q_valid` drops next edge.
- Send bits 1,1 then `L`=1 with `E`=1,`w`=0, then 1,1,0 → `Q`=4'h6; earlier partial bits absent.
- Assert `reset` with 3 bits accumulated and a word pending → `Q`=0, `q_valid`=0, `overrun`=0; next 4 bits 1,0,0,1 → `Q`=4'h9.

Source files
------------

// File: rtl/mux_dff_pkg.sv
// Shared types and helpers for the mux/DFF serial-link receiver.
package mux_dff_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        PENDING = 1'b1
    } deser_state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/mux_dff_stage.sv
// One bit of the receive shift register: clear beats shift beats hold.
module mux_dff_stage (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic clr_val,
    input  logic shift,
    input  logic d,
    output logic q
);

    // clr_val lets the entry stage capture w on a frame-sync cycle that also shifts
    always_ff @(posedge clk) begin
        if (reset)
            q <= 1'b0;
        else if (clr)
            q <= clr_val;
        else if (shift)
            q <= d;
    end

endmodule

// File: rtl/mux_dff_deser.sv
// Serial-in/parallel-out word receiver with valid/ready output and sticky overrun.
module mux_dff_deser
    import mux_dff_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w,
    input  logic             E,
    input  logic             L,
    output logic [WIDTH-1:0] Q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             overrun
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] new_word;
    logic [CW-1:0]    cnt;
    deser_state_t     state;
    deser_state_t     next_state;
    logic             complete;
    logic             handshake;
    logic             load_q;
    logic             set_ovr;

    // The entry stage takes w; every other stage takes its upstream neighbour
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        logic d_i;
        logic clr_i;

        if ((MSB_FIRST != 0 && i == 0) || (MSB_FIRST == 0 && i == WIDTH - 1)) begin : g_entry
            assign d_i   = w;
            assign clr_i = E & w;
        end else if (MSB_FIRST != 0) begin : g_up
            assign d_i   = sr[i-1];
            assign clr_i = 1'b0;
        end else begin : g_down
            assign d_i   = sr[i+1];
            assign clr_i = 1'b0;
        end

        mux_dff_stage u_stage (
            .clk     (clk),
            .reset   (reset),
            .clr     (L),
            .clr_val (clr_i),
            .shift   (E),
            .d       (d_i),
            .q       (sr[i])
        );
    end

    always_comb begin
        if (MSB_FIRST != 0)
            new_word = {sr[WIDTH-2:0], w};
        else
            new_word = {w, sr[WIDTH-1:1]};
    end

    assign complete  = E & ~L & (cnt == LAST);
    assign handshake = (state == PENDING) & q_ready;
    assign q_valid   = (state == PENDING);

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (L)
            cnt <= E ? CW'(1) : '0;
        else if (E)
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= COLLECT;
        else
            state <= next_state;
    end

    // A completion while a word is pending only replaces it if that word leaves this cycle
    always_comb begin
        next_state = state;
        load_q     = 1'b0;
        set_ovr    = 1'b0;
        case (state)
            COLLECT: begin
                if (complete) begin
                    load_q     = 1'b1;
                    next_state = PENDING;
                end
            end
            PENDING: begin
                if (complete) begin
                    if (handshake)
                        load_q = 1'b1;
                    else
                        set_ovr = 1'b1;
                end else if (handshake) begin
                    next_state = COLLECT;
                end
            end
            default: next_state = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Q       <= '0;
            overrun <= 1'b0;
        end else begin
            if (load_q)
                Q <= new_word;
            if (set_ovr)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_dff_deser.sv
// Bench for mux_dff_deser: MSB-first and LSB-first instances share one stimulus stream.
module tb_mux_dff_deser;

    logic       clk = 1'b0;
    logic       reset, w, E, L, q_ready;
    logic [3:0] q_m, q_l;
    logic       qv_m, qv_l, ov_m, ov_l;

    int checks   = 0;
    int failures = 0;

    int       bits[$];
    logic [3:0] m_qm, m_ql;
    logic     m_valid, m_ovr;
    bit       armed = 1'b0;

    always #5 clk = ~clk;

    mux_dff_deser #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(reset), .w(w), .E(E), .L(L),
        .Q(q_m), .q_valid(qv_m), .q_ready(q_ready), .overrun(ov_m)
    );

    mux_dff_deser #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .w(w), .E(E), .L(L),
        .Q(q_l), .q_valid(qv_l), .q_ready(q_ready), .overrun(ov_l)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: collect bits into a list, build the word from the list when it fills
    task automatic modelStep();
        bit         hs, done;
        logic [3:0] wm, wl;
        if (reset) begin
            bits.delete();
            m_qm = 4'h0; m_ql = 4'h0; m_valid = 1'b0; m_ovr = 1'b0;
            armed = 1'b1;
        end else if (armed) begin
            hs   = m_valid && q_ready;
            done = 1'b0;
            wm = 4'h0; wl = 4'h0;
            if (L) begin
                bits.delete();
                if (E) bits.push_back(int'(w));
            end else if (E) begin
                bits.push_back(int'(w));
                if (bits.size() == 4) begin
                    done = 1'b1;
                    foreach (bits[k]) begin
                        wm = 4'((int'(wm) * 2) + bits[k]);
                        wl = 4'(int'(wl) + (bits[k] << k));
                    end
                    bits.delete();
                end
            end
            if (done) begin
                if (!m_valid || hs) begin
                    m_qm = wm; m_ql = wl; m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (hs) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic l,
                                 input logic b, input logic rdy);
        reset = r; E = e; L = l; w = b; q_ready = rdy;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        #1;
    endtask

    task automatic sendBits(input logic [3:0] v, input int n, input logic rdy);
        for (int i = n - 1; i >= 0; i--)
            applyStimulus(1'b0, 1'b1, 1'b0, v[i], rdy);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                checkOutput("cmp_q_msb",  32'(q_m),  32'(m_qm));
                checkOutput("cmp_q_lsb",  32'(q_l),  32'(m_ql));
                checkOutput("cmp_qv_msb", 32'(qv_m), 32'(m_valid));
                checkOutput("cmp_qv_lsb", 32'(qv_l), 32'(m_valid));
                checkOutput("cmp_ov_msb", 32'(ov_m), 32'(m_ovr));
                checkOutput("cmp_ov_lsb", 32'(ov_l), 32'(m_ovr));
            end
        end
    end

    initial begin
        reset = 1'b1; E = 1'b0; L = 1'b0; w = 1'b0; q_ready = 1'b0;
        @(negedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_q", 32'(q_m), 32'h0);
        checkOutput("rst_qv", 32'(qv_m), 32'h0);
        checkOutput("rst_ov", 32'(ov_m), 32'h0);

        // basic word, both bit orders
        sendBits(4'b1100, 4, 1'b1);
        checkOutput("basic_q_msb", 32'(q_m), 32'hC);
        checkOutput("basic_q_lsb", 32'(q_l), 32'h3);
        checkOutput("basic_qv", 32'(qv_m), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("basic_qv_drop", 32'(qv_m), 32'h0);
        checkOutput("basic_q_hold", 32'(q_m), 32'hC);

        // enable gaps between bits
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("gap_q_msb", 32'(q_m), 32'hA);
        checkOutput("gap_q_lsb", 32'(q_l), 32'h5);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("gap_qv_drop", 32'(qv_m), 32'h0);

        // overrun: consumer stalled across two words
        sendBits(4'b0101, 4, 1'b0);
        checkOutput("ovr_first_q", 32'(q_m), 32'h5);
        sendBits(4'b1001, 4, 1'b0);
        checkOutput("ovr_q_kept", 32'(q_m), 32'h5);
        checkOutput("ovr_flag", 32'(ov_m), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovr_qv_drop", 32'(qv_m), 32'h0);
        checkOutput("ovr_sticky", 32'(ov_m), 32'h1);

        // frame sync with a bit on the same cycle
        sendBits(4'b0011, 2, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        sendBits(4'b0110, 3, 1'b1);
        checkOutput("sync_q", 32'(q_m), 32'h6);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // frame sync on the cycle that would have completed a word
        sendBits(4'b0111, 3, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("sync_discard_qv", 32'(qv_m), 32'h0);
        sendBits(4'b0000, 3, 1'b1);
        checkOutput("sync_discard_q", 32'(q_m), 32'h8);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // reset with a word pending and a partial word in flight
        sendBits(4'b1111, 4, 1'b0);
        sendBits(4'b0101, 3, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("midrst_q", 32'(q_m), 32'h0);
        checkOutput("midrst_qv", 32'(qv_m), 32'h0);
        checkOutput("midrst_ov", 32'(ov_m), 32'h0);
        sendBits(4'b1001, 4, 1'b0);
        checkOutput("midrst_next_q", 32'(q_m), 32'h9);

        // completion coincident with handshake replaces Q without overrun
        sendBits(4'b0001, 3, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("swap_q", 32'(q_m), 32'h3);
        checkOutput("swap_qv", 32'(qv_m), 32'h1);
        checkOutput("swap_ov", 32'(ov_m), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("swap_qv_drop", 32'(qv_m), 32'h0);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
